sdram_frame_seq: RTL and testbench

Parametrised frame sequencer placed between the image capture/display paths and the SDRAM command interface. It converts whole-frame write and read requests into burst commands with generated addresses. It arbitrates between one write channel and one read channel, and rotates frames across NUM_BUF buffers so the reader never reads a buffer that is being written. It replaces the single-address, fixed-count write sequencer.

---
 rtl/sdram_frame_seq.sv | 136 +++++++++++++
 tb/tb_sdram_frame_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sdram_frame_seq.sv
// Frame sequencer: turns whole-frame write/read requests into SDRAM burst commands,
// alternating the two channels burst by burst and rotating frames over NUM_BUF buffers.
module sdram_frame_seq #(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned BURST_LEN   = 8,
  parameter int unsigned FRAME_WORDS = 76800,
  parameter int unsigned BUF_STRIDE  = 131072,
  parameter int unsigned NUM_BUF     = 3
) (
  input  logic              S_CLK,
  input  logic              RST_N,
  input  logic              wr_start,
  input  logic              rd_start,
  output logic              wr_busy,
  output logic              rd_busy,
  output logic              wr_frame_done,
  output logic              rd_frame_done,
  output logic [1:0]        wr_buf,
  output logic [1:0]        rd_buf,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_we,
  output logic [ADDR_W-1:0] cmd_addr,
  input  logic              burst_done
);

  localparam int unsigned NUM_BURSTS = FRAME_WORDS / BURST_LEN;
  localparam int unsigned CNT_W      = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam logic [CNT_W-1:0] LAST_BURST = CNT_W'(NUM_BURSTS - 1);
  localparam logic [1:0]       LAST_BUF   = 2'(NUM_BUF - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e            state;
  logic [CNT_W-1:0]  wr_cnt;
  logic [CNT_W-1:0]  rd_cnt;
  logic [1:0]        last_complete;
  logic              has_frame;
  logic              gnt_rd;
  logic [1:0]        wr_sel_next;
  logic [1:0]        wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

  function automatic logic [1:0] next_buf(input logic [1:0] b);
    return (b >= LAST_BUF) ? 2'd0 : b + 2'd1;
  endfunction

  // Writer never lands on the buffer the reader is still scanning.
  assign wr_sel_next = next_buf(wr_buf);
  assign wr_sel      = (rd_busy && (wr_sel_next == rd_buf)) ? next_buf(wr_sel_next) : wr_sel_next;

  assign wr_addr = ADDR_W'(wr_buf) * ADDR_W'(BUF_STRIDE) + ADDR_W'(wr_cnt) * ADDR_W'(BURST_LEN);
  assign rd_addr = ADDR_W'(rd_buf) * ADDR_W'(BUF_STRIDE) + ADDR_W'(rd_cnt) * ADDR_W'(BURST_LEN);

  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= StIdle;
      wr_busy       <= 1'b0;
      rd_busy       <= 1'b0;
      wr_frame_done <= 1'b0;
      rd_frame_done <= 1'b0;
      wr_buf        <= 2'd0;
      rd_buf        <= 2'd0;
      cmd_valid     <= 1'b0;
      cmd_we        <= 1'b0;
      cmd_addr      <= '0;
      wr_cnt        <= '0;
      rd_cnt        <= '0;
      last_complete <= 2'd0;
      has_frame     <= 1'b0;
      gnt_rd        <= 1'b1;
    end else begin
      wr_frame_done <= 1'b0;
      rd_frame_done <= 1'b0;

      if (wr_start && !wr_busy) begin
        wr_buf  <= wr_sel;
        wr_busy <= 1'b1;
        wr_cnt  <= '0;
      end
      if (rd_start && !rd_busy) begin
        rd_buf  <= has_frame ? last_complete : 2'd0;
        rd_busy <= 1'b1;
        rd_cnt  <= '0;
      end

      unique case (state)
        StIdle: begin
          if (wr_busy || rd_busy) begin
            // With both channels pending, gnt_rd still names the previous winner.
            if (wr_busy && (!rd_busy || gnt_rd)) begin
              gnt_rd   <= 1'b0;
              cmd_we   <= 1'b1;
              cmd_addr <= wr_addr;
            end else begin
              gnt_rd   <= 1'b1;
              cmd_we   <= 1'b0;
              cmd_addr <= rd_addr;
            end
            cmd_valid <= 1'b1;
            state     <= StIssue;
          end
        end
        StIssue: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= StWait;
          end
        end
        StWait: begin
          if (burst_done) begin
            state <= StIdle;
            if (gnt_rd) begin
              rd_cnt <= rd_cnt + 1'b1;
              if (rd_cnt == LAST_BURST) begin
                rd_busy       <= 1'b0;
                rd_frame_done <= 1'b1;
              end
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
              if (wr_cnt == LAST_BURST) begin
                wr_busy       <= 1'b0;
                wr_frame_done <= 1'b1;
                last_complete <= wr_buf;
                has_frame     <= 1'b1;
              end
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_frame_seq.sv
// Directed bench for sdram_frame_seq: 32-word frames, 8-word bursts, 3 buffers 64 words apart.
module tb_sdram_frame_seq;

  logic        S_CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        wr_start = 1'b0;
  logic        rd_start = 1'b0;
  logic        wr_busy;
  logic        rd_busy;
  logic        wr_frame_done;
  logic        rd_frame_done;
  logic [1:0]  wr_buf;
  logic [1:0]  rd_buf;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic        cmd_we;
  logic [19:0] cmd_addr;
  logic        burst_done = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  sdram_frame_seq #(
    .ADDR_W      (20),
    .BURST_LEN   (8),
    .FRAME_WORDS (32),
    .BUF_STRIDE  (64),
    .NUM_BUF     (3)
  ) dut (
    .S_CLK         (S_CLK),
    .RST_N         (RST_N),
    .wr_start      (wr_start),
    .rd_start      (rd_start),
    .wr_busy       (wr_busy),
    .rd_busy       (rd_busy),
    .wr_frame_done (wr_frame_done),
    .rd_frame_done (rd_frame_done),
    .wr_buf        (wr_buf),
    .rd_buf        (rd_buf),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_we        (cmd_we),
    .cmd_addr      (cmd_addr),
    .burst_done    (burst_done)
  );

  always #5 S_CLK = ~S_CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge S_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Wait for a command, check it, accept it (cmd_ready=1) and return burst_done 4 cycles later.
  task automatic do_burst(input string tag, input logic we, input logic [19:0] addr);
    int n = 0;
    while (cmd_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, 32'(cmd_valid), 32'd1);
    chk({tag, "_we"}, 32'(cmd_we), 32'(we));
    chk({tag, "_addr"}, 32'(cmd_addr), 32'(addr));
    step();
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_one_accept"}, 32'(cmd_valid), 32'd0);
      step();
    end
    burst_done = 1'b1;
    step();
    burst_done = 1'b0;
  endtask

  task automatic write_frame(input string tag, input int b);
    wr_start = 1'b1;
    step();
    wr_start = 1'b0;
    chk({tag, "_buf"}, 32'(wr_buf), 32'(b));
    chk({tag, "_busy"}, 32'(wr_busy), 32'd1);
    for (int i = 0; i < 4; i++) do_burst(tag, 1'b1, 20'(b * 64 + i * 8));
    chk({tag, "_done"}, 32'(wr_frame_done), 32'd1);
    chk({tag, "_idle"}, 32'(wr_busy), 32'd0);
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst_wr_busy", 32'(wr_busy), 32'd0);
    chk("rst_rd_busy", 32'(rd_busy), 32'd0);
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    chk("rst_addr", 32'(cmd_addr), 32'd0);
    chk("rst_bufs", {28'd0, wr_buf, rd_buf}, 32'd0);
    chk("rst_done", {30'd0, wr_frame_done, rd_frame_done}, 32'd0);
    RST_N = 1'b1;
    step();

    // Single write into buffer 1
    write_frame("w1", 1);
    step();
    chk("w1_pulse_once", 32'(wr_frame_done), 32'd0);

    // Read of the completed frame
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    chk("r1_buf", 32'(rd_buf), 32'd1);
    chk("r1_busy", 32'(rd_busy), 32'd1);
    for (int i = 0; i < 4; i++) do_burst("r1", 1'b0, 20'(64 + i * 8));
    chk("r1_done", 32'(rd_frame_done), 32'd1);
    chk("r1_idle", 32'(rd_busy), 32'd0);

    // Concurrent frames: write to buffer 2 and read buffer 1, interleaved W first
    wr_start = 1'b1;
    rd_start = 1'b1;
    step();
    wr_start = 1'b0;
    rd_start = 1'b0;
    chk("cc_wr_buf", 32'(wr_buf), 32'd2);
    chk("cc_rd_buf", 32'(rd_buf), 32'd1);
    for (int i = 0; i < 4; i++) begin
      do_burst("cc_w", 1'b1, 20'(128 + i * 8));
      do_burst("cc_r", 1'b0, 20'(64 + i * 8));
    end
    chk("cc_rd_done", 32'(rd_frame_done), 32'd1);
    chk("cc_both_idle", {30'd0, wr_busy, rd_busy}, 32'd0);

    // Backpressure: next write goes to buffer 0, first command held 10 cycles
    cmd_ready = 1'b0;
    wr_start  = 1'b1;
    step();
    wr_start = 1'b0;
    chk("bp_buf", 32'(wr_buf), 32'd0);
    step();
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(cmd_valid), 32'd1);
      chk("bp_addr", 32'(cmd_addr), 32'd0);
      chk("bp_we", 32'(cmd_we), 32'd1);
      step();
    end
    cmd_ready = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("bp_one_accept", 32'(cmd_valid), 32'd0);
      step();
    end
    burst_done = 1'b1;
    step();
    burst_done = 1'b0;
    for (int i = 1; i < 4; i++) do_burst("bp", 1'b1, 20'(i * 8));
    chk("bp_done", 32'(wr_frame_done), 32'd1);

    // Wrap 1, 2, 0 with an ignored mid-frame start and a spurious burst_done in IDLE
    wr_start = 1'b1;
    step();
    wr_start = 1'b0;
    chk("wr_a_buf", 32'(wr_buf), 32'd1);
    do_burst("wr_a", 1'b1, 20'd64);
    wr_start   = 1'b1;
    burst_done = 1'b1;
    step();
    wr_start   = 1'b0;
    burst_done = 1'b0;
    chk("wr_a_ignore_buf", 32'(wr_buf), 32'd1);
    for (int i = 1; i < 4; i++) do_burst("wr_a", 1'b1, 20'(64 + i * 8));
    chk("wr_a_done", 32'(wr_frame_done), 32'd1);
    write_frame("wr_b", 2);
    write_frame("wr_c", 0);

    // Reset in the middle of a frame
    wr_start = 1'b1;
    step();
    wr_start = 1'b0;
    chk("rm_buf", 32'(wr_buf), 32'd1);
    do_burst("rm", 1'b1, 20'd64);
    do_burst("rm", 1'b1, 20'd72);
    step();
    chk("rm_third_valid", 32'(cmd_valid), 32'd1);
    RST_N = 1'b0;
    #1;
    chk("rm_valid", 32'(cmd_valid), 32'd0);
    chk("rm_busy", {30'd0, wr_busy, rd_busy}, 32'd0);
    chk("rm_bufs", {28'd0, wr_buf, rd_buf}, 32'd0);
    chk("rm_addr_we", {11'd0, cmd_we, cmd_addr}, 32'd0);
    step();
    RST_N = 1'b1;
    step();
    write_frame("rs", 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
